serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor. Computes diff = a - b, one bit per clock, LSB first.
- Companion to the 5-bit ripple adder in the arithmetic (sumador) area. Same operand/result widths: WIDTH-bit operands, WIDTH+1-bit result. Opposite operation.
- Start/busy/done handshake lets a controller time-share one bit-slice instead of a full parallel subtractor.

---
 rtl/serial_subtractor.sv | 142 ++++++++++++++
 tb/tb_serial_subtractor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, with a start/busy/done handshake.
// Define SERIAL_SUBTRACTOR_ADD_MODE_EN to add an op port selecting add (op=1) or subtract (op=0).
module serial_subtractor #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   diff
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   diff_q, diff_d;
  logic             add_mode;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic op_q, op_d;
  assign add_mode = op_q;
`else
  assign add_mode = 1'b0;
`endif

  // One-bit slice; br_q holds the borrow when subtracting and the carry when adding.
  logic a0, b0, x0, bit_d, borrow_nxt, carry_nxt, br_nxt;
  always_comb begin
    a0         = a_q[0];
    b0         = b_q[0];
    x0         = a0 ^ b0;
    bit_d      = x0 ^ br_q;
    borrow_nxt = (~a0 & b0) | (~x0 & br_q);
    carry_nxt  = (a0 & b0) | (br_q & x0);
    br_nxt     = add_mode ? carry_nxt : borrow_nxt;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    op_d    = op_q;
`endif
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = StShift;
          a_d     = a;
          b_d     = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
          op_d    = op;
`endif
        end
      end
      StShift: begin
        busy_d = 1'b1;
        if (cnt_q != LastCnt) begin
          res_d = {bit_d, res_q[WIDTH-1:1]};
          a_d   = a_q >> 1;
          b_d   = b_q >> 1;
          br_d  = br_nxt;
          cnt_d = cnt_q + CntW'(1);
        end else begin
          // All bits processed: publish the result together with the done pulse.
          state_d = StDone;
          done_d  = 1'b1;
          diff_d  = {br_q, res_q};
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      op_q    <= op_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=5).
module tb_serial_subtractor;

  localparam int unsigned W = 5;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         busy;
  logic         done;
  logic [W:0]   diff;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    .op    (op),
`endif
    .busy  (busy),
    .done  (done),
    .diff  (diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one operation from IDLE and checks result, latency, busy length and single done.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic opv, input logic [W:0] exp);
    int bc, dc, dl;
    logic [W:0] dv;
    bc = 0; dc = 0; dl = -1; dv = '0;
    a = av; b = bv; op = opv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~av; b = ~bv; op = ~opv;
    for (int i = 0; i < 20; i++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        dl = i;
        dv = diff;
      end
      if (!busy) break;
      @(posedge clk); #1;
    end
    check({tag, " diff"}, 32'(dv), 32'(exp));
    check({tag, " done_count"}, 32'(dc), 32'd1);
    check({tag, " done_latency"}, 32'(dl), 32'(W + 1));
    check({tag, " busy_cycles"}, 32'(bc), 32'(W + 2));
    check({tag, " diff_hold"}, 32'(diff), 32'(exp));
  endtask

  logic [W-1:0] ha [3];
  logic [W-1:0] hb [3];
  logic [W:0]   hexp [3];
  logic [W:0]   hgot [3];

  initial begin
    int dc, acc, nd;
    logic prev_busy;
    logic [W:0] dv;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("sub 20-7", 5'd20, 5'd7, 1'b0, 6'd13);
    run_op("sub 3-9", 5'd3, 5'd9, 1'b0, 6'b111010);
    run_op("sub 31-31", 5'd31, 5'd31, 1'b0, 6'd0);
    run_op("sub 0-31", 5'd0, 5'd31, 1'b0, 6'b100001);

    // Second request during SHIFT must be ignored.
    a = 5'd5; b = 5'd2; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = 5'd10; b = 5'd1;
    dc = 0; dv = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dc++;
        dv = diff;
        start = 1'b0;
      end
      if (!busy) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ignore diff", 32'(dv), 32'd3);
    check("ignore done_count", 32'(dc), 32'd1);
    check("ignore idle", 32'(busy), 32'd0);
    run_op("after ignore 12-4", 5'd12, 5'd4, 1'b0, 6'd8);

    // Asynchronous reset after the third bit has been processed.
    a = 5'd20; b = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #3 rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset diff", 32'(diff), 32'd0);
    @(posedge clk); #1;
    check("midreset held busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) dc++;
    end
    check("midreset no activity", 32'(dc), 32'd0);
    run_op("after reset 17-4", 5'd17, 5'd4, 1'b0, 6'd13);

    // start held high: each op uses the operands present at its own accept edge.
    ha[0] = 5'd20; hb[0] = 5'd7; hexp[0] = 6'd13;
    ha[1] = 5'd3;  hb[1] = 5'd9; hexp[1] = 6'b111010;
    ha[2] = 5'd9;  hb[2] = 5'd2; hexp[2] = 6'd7;
    hgot[0] = '0; hgot[1] = '0; hgot[2] = '0;
    a = ha[0]; b = hb[0]; op = 1'b0; start = 1'b1;
    acc = 0; nd = 0; prev_busy = busy;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) begin
        acc++;
        if (acc < 3) begin
          a = ha[acc]; b = hb[acc];
        end else begin
          start = 1'b0;
        end
      end
      if (done) begin
        if (nd < 3) hgot[nd] = diff;
        nd++;
      end
      prev_busy = busy;
      if (nd >= 3 && !busy) break;
    end
    start = 1'b0;
    check("held done_count", 32'(nd), 32'd3);
    check("held accept_count", 32'(acc), 32'd3);
    check("held diff0", 32'(hgot[0]), 32'(hexp[0]));
    check("held diff1", 32'(hgot[1]), 32'(hexp[1]));
    check("held diff2", 32'(hgot[2]), 32'(hexp[2]));

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    run_op("add 31+31", 5'd31, 5'd31, 1'b1, 6'b111110);
    run_op("add 0+0", 5'd0, 5'd0, 1'b1, 6'd0);
    run_op("add 13+6", 5'd13, 5'd6, 1'b1, 6'd19);
    run_op("sub 8-9", 5'd8, 5'd9, 1'b0, 6'b111111);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
